qsub_pipe: RTL and testbench

Pipelined, handshaked signed subtractor: computes o_diff = sat(i_a − i_b) in two registered stages and saturates to a configurable output width. It is the inverse-direction companion of the signed adder in the DSP building-block set. It sits in datapaths that need difference terms, such as error signals and first differences. It carries valid/ready flow control so it can sit between elastic stages.

---
 rtl/qsub_pkg.sv | 22 ++
 rtl/qsub_sat_trunc.sv | 29 ++
 rtl/qsub_pipe.sv | 105 ++++++++++
 tb/tb_qsub_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsub_pkg.sv
// Shared sizing helpers and saturation bounds for the qsub/qadd family of
// signed arithmetic blocks.
package qsub_pkg;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One guard bit above the wider operand makes a +/- of two signed values exact.
    function automatic int calc_fw(input int aw, input int bw);
        return max2(aw, bw) + 1;
    endfunction

    function automatic longint sat_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

endpackage

// File: rtl/qsub_sat_trunc.sv
// Combinational signed saturator: narrows an IW-bit value to OW bits,
// clipping to the OW-bit range and flagging when it had to clip.
module sat_trunc
    import qsub_pkg::*;
#(
    parameter int IW = 17,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din_i,
    output logic signed [OW-1:0] dout_o,
    output logic                 clip_o
);

    localparam logic signed [IW-1:0] MaxV = IW'(sat_max(OW));
    localparam logic signed [IW-1:0] MinV = IW'(sat_min(OW));

    always_comb begin
        dout_o = din_i[OW-1:0];
        clip_o = 1'b0;
        if (din_i > MaxV) begin
            dout_o = MaxV[OW-1:0];
            clip_o = 1'b1;
        end else if (din_i < MinV) begin
            dout_o = MinV[OW-1:0];
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/qsub_pipe.sv
// Two-stage elastic signed subtractor: full-precision difference in stage 1,
// saturation to OWIDTH in stage 2, with a sticky count of clipped results.
module qsub_pipe
    import qsub_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 16,
    parameter int OWIDTH = 16,
    parameter int CNTW   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [AWIDTH-1:0] i_a,
    input  logic signed [BWIDTH-1:0] i_b,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [OWIDTH-1:0] o_diff,
    output logic                     o_sat,
    output logic [CNTW-1:0]          o_sat_cnt
);

    localparam int FW = calc_fw(AWIDTH, BWIDTH);

    logic signed [FW-1:0]     aExt, bExt, diffFull;
    logic signed [OWIDTH-1:0] satDiff;
    logic                     satClip;
    logic                     load1, load2;

    logic                     s1Valid_q, s1Valid_d;
    logic signed [FW-1:0]     s1Diff_q, s1Diff_d;
    logic                     outValid_q, outValid_d;
    logic signed [OWIDTH-1:0] outDiff_q, outDiff_d;
    logic                     outSat_q, outSat_d;
    logic [CNTW-1:0]          satCnt_q, satCnt_d;

    assign aExt     = FW'(i_a);
    assign bExt     = FW'(i_b);
    assign diffFull = aExt - bExt;

    // Stage 2 frees up when empty or draining; stage 1 may then refill behind it.
    assign load2   = !outValid_q || i_ready;
    assign load1   = !s1Valid_q || load2;
    assign o_ready = load1;

    sat_trunc #(
        .IW(FW),
        .OW(OWIDTH)
    ) u_sat (
        .din_i (s1Diff_q),
        .dout_o(satDiff),
        .clip_o(satClip)
    );

    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1Diff_d   = s1Diff_q;
        outValid_d = outValid_q;
        outDiff_d  = outDiff_q;
        outSat_d   = outSat_q;
        satCnt_d   = satCnt_q;

        if (load1) begin
            s1Valid_d = i_valid;
            if (i_valid) s1Diff_d = diffFull;
        end

        if (load2) begin
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                outDiff_d = satDiff;
                outSat_d  = satClip;
            end
        end

        // Count clipped results as they leave, sticking at all-ones.
        if (outValid_q && i_ready && outSat_q && (satCnt_q != '1))
            satCnt_d = satCnt_q + CNTW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1Valid_q  <= 1'b0;
            s1Diff_q   <= '0;
            outValid_q <= 1'b0;
            outDiff_q  <= '0;
            outSat_q   <= 1'b0;
            satCnt_q   <= '0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Diff_q   <= s1Diff_d;
            outValid_q <= outValid_d;
            outDiff_q  <= outDiff_d;
            outSat_q   <= outSat_d;
            satCnt_q   <= satCnt_d;
        end
    end

    assign o_valid   = outValid_q;
    assign o_diff    = outDiff_q;
    assign o_sat     = outSat_q;
    assign o_sat_cnt = satCnt_q;

endmodule

// File: tb/tb_qsub_pipe.sv
// Bench for qsub_pipe: three instances (default, 17-bit output, 2-bit counter)
// share one stimulus stream and are compared each cycle against a transaction-level model.
module tb_qsub_pipe;

    logic clk;
    logic rst;
    logic iValid;
    logic iReady;
    logic signed [15:0] iA, iB;

    logic oReady, oValid, oSat;
    logic signed [15:0] oDiff;
    logic [15:0] oCnt;

    logic oReadyW, oValidW, oSatW;
    logic signed [16:0] oDiffW;
    logic [15:0] oCntW;

    logic oReadyC, oValidC, oSatC;
    logic signed [15:0] oDiffC;
    logic [1:0] oCntC;

    int checks = 0;
    int errors = 0;

    qsub_pipe dut (
        .i_clk(clk), .i_rst(rst), .i_valid(iValid), .o_ready(oReady),
        .i_a(iA), .i_b(iB), .o_valid(oValid), .i_ready(iReady),
        .o_diff(oDiff), .o_sat(oSat), .o_sat_cnt(oCnt)
    );

    qsub_pipe #(.OWIDTH(17)) dutW (
        .i_clk(clk), .i_rst(rst), .i_valid(iValid), .o_ready(oReadyW),
        .i_a(iA), .i_b(iB), .o_valid(oValidW), .i_ready(iReady),
        .o_diff(oDiffW), .o_sat(oSatW), .o_sat_cnt(oCntW)
    );

    qsub_pipe #(.CNTW(2)) dutC (
        .i_clk(clk), .i_rst(rst), .i_valid(iValid), .o_ready(oReadyC),
        .i_a(iA), .i_b(iB), .o_valid(oValidC), .i_ready(iReady),
        .o_diff(oDiffC), .o_sat(oSatC), .o_sat_cnt(oCntC)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic longint satTo(input longint v, input int ow);
        longint hi, lo;
        hi = (64'sd1 <<< (ow - 1)) - 1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint clipped(input longint v, input int ow);
        return (satTo(v, ow) != v) ? 64'sd1 : 64'sd0;
    endfunction

    // Transaction-level model: a queue of accepted pairs tagged with acceptance cycle.
    typedef struct {
        longint a;
        longint b;
        int     acc;
    } txn_t;

    txn_t   mq[$];
    int     cyc;
    longint mCnt, mCntW, mCntC;
    longint outLog[$];
    bit     sawNotReady;

    function automatic bit modelValid();
        if (mq.size() == 0) return 1'b0;
        return cyc >= mq[0].acc + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            outLog.delete();
            cyc   = 0;
            mCnt  = 0;
            mCntW = 0;
            mCntC = 0;
        end else begin
            bit mv, accept, xfer;
            longint d;
            txn_t t;
            mv     = modelValid();
            accept = iValid && ((mq.size() < 2) || iReady);
            xfer   = mv && iReady;
            if (oValid && iReady) outLog.push_back(longint'(oDiff));
            cyc++;
            if (xfer) begin
                d = mq[0].a - mq[0].b;
                if (clipped(d, 16) != 0) begin
                    if (mCnt < 65535) mCnt++;
                    if (mCntC < 3) mCntC++;
                end
                if (clipped(d, 17) != 0 && mCntW < 65535) mCntW++;
                void'(mq.pop_front());
            end
            if (accept) begin
                t.a   = longint'(iA);
                t.b   = longint'(iB);
                t.acc = cyc;
                mq.push_back(t);
            end
        end
    end

    // Every cycle, all three instances are held against the model.
    always @(negedge clk) begin
        bit ev;
        longint d;
        ev = modelValid();
        if (!oReady) sawNotReady = 1'b1;
        chk("o_ready", longint'(oReady), longint'((mq.size() < 2) || iReady));
        chk("o_ready_w", longint'(oReadyW), longint'((mq.size() < 2) || iReady));
        chk("o_valid", longint'(oValid), longint'(ev));
        chk("o_valid_c", longint'(oValidC), longint'(ev));
        if (ev) begin
            d = mq[0].a - mq[0].b;
            chk("o_diff", longint'(oDiff), satTo(d, 16));
            chk("o_sat", longint'(oSat), clipped(d, 16));
            chk("o_diff_w", longint'(oDiffW), satTo(d, 17));
            chk("o_sat_w", longint'(oSatW), clipped(d, 17));
            chk("o_diff_c", longint'(oDiffC), satTo(d, 16));
        end
        chk("o_sat_cnt", longint'(oCnt), mCnt);
        chk("o_sat_cnt_w", longint'(oCntW), mCntW);
        chk("o_sat_cnt_c", longint'(oCntC), mCntC);
    end

    task automatic sendOne(input int a, input int b);
        bit done;
        bit rdy;
        done   = 1'b0;
        iValid = 1'b1;
        iA     = 16'(a);
        iB     = 16'(b);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            rdy = oReady;
            @(posedge clk);
            #1;
            done = rdy;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input int a, input int b, input longint expDiff,
                                 input longint expSat, input longint expDiffW,
                                 input longint expCnt, input longint expCntC);
        sendOne(a, b);
        iValid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", longint'(oValid), 0);
        @(negedge clk);
        chk("lat_valid", longint'(oValid), 1);
        chk("lit_diff", longint'(oDiff), expDiff);
        chk("lit_sat", longint'(oSat), expSat);
        chk("lit_diff_w", longint'(oDiffW), expDiffW);
        @(posedge clk);
        #1;
        chk("lit_cnt", longint'(oCnt), expCnt);
        chk("lit_cnt_c", longint'(oCntC), expCntC);
    endtask

    task automatic checkOutput(input longint exp[$]);
        chk("log_len", longint'(outLog.size()), longint'(exp.size()));
        for (int i = 0; i < exp.size() && i < outLog.size(); i++)
            chk("log_item", outLog[i], exp[i]);
    endtask

    initial begin
        longint expStream[$];
        longint expOne[$];
        rst         = 1'b1;
        iValid      = 1'b0;
        iReady      = 1'b1;
        iA          = '0;
        iB          = '0;
        sawNotReady = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(oValid), 0);
        chk("rst_diff", longint'(oDiff), 0);
        chk("rst_cnt", longint'(oCnt), 0);
        chk("rst_ready", longint'(oReady), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(100, 30, 70, 0, 70, 0, 0);
        applyStimulus(-5, 20, -25, 0, -25, 0, 0);
        applyStimulus(-32768, 1, -32768, 1, -32769, 1, 1);
        applyStimulus(32767, -1, 32767, 1, 32768, 2, 2);
        applyStimulus(-32768, 32767, -32768, 1, -65535, 3, 3);
        applyStimulus(32767, -32768, 32767, 1, 65535, 4, 3);
        applyStimulus(-32768, 32767, -32768, 1, -65535, 5, 3);

        // Stream 1..6 with a three-cycle downstream stall partway through.
        outLog.delete();
        sawNotReady = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) sendOne(i, 0);
                iValid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 iReady = 1'b0;
                repeat (3) @(posedge clk);
                #1 iReady = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_ready_dropped", longint'(sawNotReady), 1);
        expStream = '{1, 2, 3, 4, 5, 6};
        checkOutput(expStream);

        // Fill both stages, then reset asynchronously in the middle of a cycle.
        iReady = 1'b0;
        sendOne(11, 1);
        sendOne(12, 2);
        iValid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("amid_valid", longint'(oValid), 0);
        chk("amid_diff", longint'(oDiff), 0);
        chk("amid_cnt", longint'(oCnt), 0);
        chk("amid_ready", longint'(oReady), 1);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        iReady = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(7, 2, 5, 0, 5, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        expOne = '{5};
        checkOutput(expOne);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
